// File: rtl/solution_player.sv
// Playback sequencer for the solved 6-puzzle move list: debounces the board buttons and
// steps the displayed move index manually or on an auto-play timer.
module solution_player #(
  parameter int unsigned DEB_CYCLES  = 20000,
  parameter int unsigned STEP_CYCLES = 25000000,
  parameter int unsigned MAX_MOVES   = 22
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     comp,
  input  logic [4:0]               cnt,
  input  logic [2*MAX_MOVES-1:0]   ord,
  input  logic [4:0]               btn,
  output logic [4:0]               idx,
  output logic [1:0]               move,
  output logic                     move_vld,
  output logic                     playing,
  output logic                     at_end
);

  localparam int unsigned TW = (STEP_CYCLES > 2) ? $clog2(STEP_CYCLES) : 1;
  localparam int unsigned DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_PAUSE, S_PLAY, S_DONE} state_t;
  typedef enum logic [2:0] {ACT_NONE, ACT_HOME, ACT_END, ACT_PREV, ACT_NEXT, ACT_PLAY} act_t;

  logic [4:0]    sync1_q, sync2_q, deb_q, pulse_q;
  logic [DW-1:0] dcnt_q [5];

  state_t        state_q, state_d;
  logic [4:0]    idx_q, idx_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [4:0]    cnt_c;
  act_t          act;
  logic [1:0]    move_sel;

  // Counter tracks how long the synced level has disagreed with the accepted level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
      pulse_q <= '0;
      for (int unsigned i = 0; i < 5; i++) dcnt_q[i] <= '0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
      pulse_q <= '0;
      for (int unsigned i = 0; i < 5; i++) begin
        if (sync2_q[i] != deb_q[i]) begin
          if (dcnt_q[i] == DW'(DEB_CYCLES - 1)) begin
            deb_q[i]   <= sync2_q[i];
            pulse_q[i] <= sync2_q[i];
            dcnt_q[i]  <= '0;
          end else begin
            dcnt_q[i] <= dcnt_q[i] + 1'b1;
          end
        end else begin
          dcnt_q[i] <= '0;
        end
      end
    end
  end

  assign cnt_c = (cnt > 5'(MAX_MOVES)) ? 5'(MAX_MOVES) : cnt;

  always_comb begin
    act = ACT_NONE;
    if      (pulse_q[1]) act = ACT_HOME;
    else if (pulse_q[0]) act = ACT_END;
    else if (pulse_q[3]) act = ACT_PREV;
    else if (pulse_q[4]) act = ACT_NEXT;
    else if (pulse_q[2]) act = ACT_PLAY;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      timer_q <= timer_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    timer_d = '0;
    unique case (state_q)
      S_IDLE: begin
        idx_d = '0;
        if (comp) state_d = (cnt_c == 5'd0) ? S_DONE : S_PAUSE;
      end
      S_PAUSE, S_PLAY: begin
        unique case (act)
          ACT_HOME: idx_d = '0;
          ACT_END: begin
            idx_d   = cnt_c;
            state_d = S_DONE;
          end
          ACT_PREV: if (idx_q != 5'd0) idx_d = idx_q - 5'd1;
          ACT_NEXT: begin
            if (idx_q < cnt_c) begin
              idx_d = idx_q + 5'd1;
              if (idx_q + 5'd1 == cnt_c) state_d = S_DONE;
            end
          end
          ACT_PLAY: state_d = (state_q == S_PLAY) ? S_PAUSE : S_PLAY;
          ACT_NONE: begin
            if (state_q == S_PLAY) begin
              if (timer_q == TW'(STEP_CYCLES - 1)) begin
                idx_d = idx_q + 5'd1;
                if (idx_q + 5'd1 == cnt_c) state_d = S_DONE;
              end else begin
                timer_d = timer_q + 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
      S_DONE: begin
        if (cnt_c != 5'd0) begin
          unique case (act)
            ACT_PREV: begin
              idx_d   = idx_q - 5'd1;
              state_d = S_PAUSE;
            end
            ACT_HOME: begin
              idx_d   = '0;
              state_d = S_PAUSE;
            end
            ACT_PLAY: begin
              idx_d   = '0;
              state_d = S_PLAY;
            end
            default: ;
          endcase
        end
      end
      default: ;
    endcase
    // Losing the solution overrides every state, including a same-cycle button pulse.
    if (!comp && state_q != S_IDLE) begin
      state_d = S_IDLE;
      idx_d   = '0;
      timer_d = '0;
    end
  end

  always_comb begin
    move_sel = '0;
    for (int unsigned k = 0; k < MAX_MOVES; k++) begin
      if (idx_q == 5'(k)) move_sel = ord[2*k +: 2];
    end
    idx      = idx_q;
    playing  = (state_q == S_PLAY);
    at_end   = (state_q == S_DONE);
    move_vld = comp && (state_q != S_IDLE) && (idx_q < cnt_c);
    move     = move_vld ? move_sel : 2'b00;
  end

endmodule

// File: tb/tb_solution_player.sv
// Bench for solution_player: directed button scenarios plus random presses, checked every
// cycle against a queue-based behavioural model of debounce and playback rules.
module tb_solution_player;
  localparam int DEB = 4;
  localparam int STEP = 8;
  localparam int MAXM = 22;
  localparam int IDLE = 0, PAUSE = 1, PLAY = 2, DONE = 3;
  localparam int NONE = 0, HOME = 1, ENDB = 2, PREV = 3, NEXT = 4, PLAYB = 5;

  logic clk = 1'b0;
  logic rst_n, comp;
  logic [4:0] cnt, btn, idx;
  logic [43:0] ord;
  logic [1:0] move;
  logic move_vld, playing, at_end;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  solution_player #(.DEB_CYCLES(DEB), .STEP_CYCLES(STEP), .MAX_MOVES(MAXM)) dut (
    .clk(clk), .rst_n(rst_n), .comp(comp), .cnt(cnt), .ord(ord), .btn(btn),
    .idx(idx), .move(move), .move_vld(move_vld), .playing(playing), .at_end(at_end)
  );

  function automatic void cmp(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endfunction

  // Behavioural model
  int m_state, m_idx, m_t, m_cc, m_act;
  bit [4:0] m_deb, m_pulse;
  bit [4:0] rawq[$];
  bit all_diff;

  function automatic int pick(bit [4:0] p);
    if (p[1]) return HOME;
    if (p[0]) return ENDB;
    if (p[3]) return PREV;
    if (p[4]) return NEXT;
    if (p[2]) return PLAYB;
    return NONE;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_state = IDLE; m_idx = 0; m_t = 0; m_deb = '0; m_pulse = '0;
      rawq.delete();
      for (int k = 0; k < DEB + 2; k++) rawq.push_back(5'b0);
    end else begin
      m_cc = (cnt > MAXM) ? MAXM : int'(cnt);
      m_act = pick(m_pulse);
      if (!comp) begin
        m_state = IDLE; m_idx = 0; m_t = 0;
      end else if (m_state == IDLE) begin
        m_idx = 0; m_t = 0;
        m_state = (m_cc == 0) ? DONE : PAUSE;
      end else if (m_state == DONE) begin
        m_t = 0;
        if (m_cc > 0) begin
          if (m_act == PREV) begin m_idx = m_idx - 1; m_state = PAUSE; end
          else if (m_act == HOME) begin m_idx = 0; m_state = PAUSE; end
          else if (m_act == PLAYB) begin m_idx = 0; m_state = PLAY; end
        end
      end else begin
        if (m_act == HOME) m_idx = 0;
        else if (m_act == ENDB) begin m_idx = m_cc; m_state = DONE; end
        else if (m_act == PREV) begin if (m_idx > 0) m_idx--; end
        else if (m_act == NEXT) begin if (m_idx < m_cc) m_idx++; end
        else if (m_act == PLAYB) m_state = (m_state == PLAY) ? PAUSE : PLAY;
        else if (m_state == PLAY) begin
          m_t++;
          if (m_t == STEP) begin m_t = 0; m_idx++; end
        end
        if (m_act != NONE) m_t = 0;
        if (m_idx == m_cc) m_state = DONE;
        if (m_state != PLAY) m_t = 0;
      end
      // A level is accepted once DEB consecutive synchronized samples disagree with it.
      rawq.push_front(btn);
      void'(rawq.pop_back());
      m_pulse = '0;
      for (int b = 0; b < 5; b++) begin
        all_diff = 1'b1;
        for (int k = 2; k < DEB + 2; k++) if (rawq[k][b] == m_deb[b]) all_diff = 1'b0;
        if (all_diff) begin
          m_deb[b] = ~m_deb[b];
          m_pulse[b] = m_deb[b];
        end
      end
    end
  end

  int e_cc, e_vld, e_move;
  always @(negedge clk) begin
    if (chk_en) begin
      e_cc = (cnt > MAXM) ? MAXM : int'(cnt);
      e_vld = (comp && m_state != IDLE && m_idx < e_cc) ? 1 : 0;
      e_move = 0;
      if (e_vld == 1) e_move = int'(ord[2*m_idx +: 2]);
      cmp("idx", int'(idx), m_idx);
      cmp("move_vld", int'(move_vld), e_vld);
      cmp("move", int'(move), e_move);
      cmp("playing", int'(playing), (m_state == PLAY) ? 1 : 0);
      cmp("at_end", int'(at_end), (m_state == DONE) ? 1 : 0);
    end
  end

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  task automatic press(int b, int hold);
    btn[b] = 1'b1;
    cyc(hold);
    btn[b] = 1'b0;
    cyc(DEB + 6);
  endtask

  logic [63:0] r64;
  int r, hold;

  initial begin
    rst_n = 1'b0; comp = 1'b0; cnt = '0; ord = '0; btn = '0;
    @(posedge clk);
    chk_en = 1'b1;
    cyc(2);
    cmp("rst_idx", int'(idx), 0);
    cmp("rst_vld", int'(move_vld), 0);
    cmp("rst_playing", int'(playing), 0);
    cmp("rst_at_end", int'(at_end), 0);

    // 1: load a 3-move solution (01, 10, 11)
    rst_n = 1'b1; comp = 1'b1; cnt = 5'd3; ord = 44'h39;
    cyc(2);
    cmp("t1_idx", int'(idx), 0);
    cmp("t1_move", int'(move), 1);
    cmp("t1_vld", int'(move_vld), 1);
    cmp("t1_playing", int'(playing), 0);

    // 2: step forward to the end, then one more
    press(4, 10);
    cmp("t2_idx1", int'(idx), 1);
    cmp("t2_move1", int'(move), 2);
    press(4, 10);
    cmp("t2_idx2", int'(idx), 2);
    cmp("t2_move2", int'(move), 3);
    press(4, 10);
    cmp("t2_idx3", int'(idx), 3);
    cmp("t2_vld3", int'(move_vld), 0);
    cmp("t2_at_end", int'(at_end), 1);
    press(4, 10);
    cmp("t2_no_wrap", int'(idx), 3);

    // 3: glitch rejection and long hold
    press(1, 10);
    cmp("t3_home", int'(idx), 0);
    btn[4] = 1'b1; cyc(2); btn[4] = 1'b0; cyc(10);
    cmp("t3_glitch", int'(idx), 0);
    press(4, 40);
    cmp("t3_hold", int'(idx), 1);

    // 4: auto-play through to the end, then replay
    press(1, 10);
    btn[2] = 1'b1; cyc(7);
    cmp("t4_play", int'(playing), 1);
    cmp("t4_idx0", int'(idx), 0);
    cyc(3); btn[2] = 1'b0;
    cyc(20);
    cmp("t4_idx2", int'(idx), 2);
    cmp("t4_still_play", int'(playing), 1);
    cyc(1);
    cmp("t4_done_idx", int'(idx), 3);
    cmp("t4_done", int'(at_end), 1);
    cmp("t4_stop", int'(playing), 0);
    btn[2] = 1'b1; cyc(7);
    cmp("t4_replay", int'(playing), 1);
    cmp("t4_replay_idx", int'(idx), 0);
    btn[2] = 1'b0; cyc(10);

    // 5: priority and lower boundary
    press(0, 10);
    cmp("t5_end", int'(idx), 3);
    press(3, 10);
    cmp("t5_prev", int'(idx), 2);
    cmp("t5_paused", int'(at_end), 0);
    btn = 5'b01010; cyc(10); btn = '0; cyc(10);
    cmp("t5_home_wins", int'(idx), 0);
    press(3, 10);
    cmp("t5_prev_at0", int'(idx), 0);

    // 6: comp drop mid-play, clamped count
    press(4, 10);
    press(4, 10);
    btn[2] = 1'b1; cyc(7);
    cmp("t6_play_idx", int'(idx), 2);
    cyc(1);
    comp = 1'b0;
    cyc(1);
    cmp("t6_idle_idx", int'(idx), 0);
    cmp("t6_idle_vld", int'(move_vld), 0);
    cmp("t6_idle_play", int'(playing), 0);
    btn = '0; cyc(10);
    cnt = 5'd30; comp = 1'b1; cyc(2);
    press(0, 10);
    cmp("t6_clamp", int'(idx), 22);
    cmp("t6_clamp_end", int'(at_end), 1);

    // Empty solution goes straight to the end
    comp = 1'b0; cyc(2);
    cnt = 5'd0; comp = 1'b1; cyc(2);
    cmp("empty_end", int'(at_end), 1);
    cmp("empty_idx", int'(idx), 0);

    // Reset in the middle of playback
    comp = 1'b0; cyc(2);
    cnt = 5'd5; r64 = {$urandom(), $urandom()}; ord = r64[43:0]; comp = 1'b1; cyc(2);
    press(2, 10);
    cyc(3);
    rst_n = 1'b0; cyc(1);
    cmp("mid_rst_idx", int'(idx), 0);
    cmp("mid_rst_play", int'(playing), 0);
    cmp("mid_rst_vld", int'(move_vld), 0);
    rst_n = 1'b1; cyc(2);
    cmp("mid_rst_resume", int'(move_vld), 1);

    // Random phase
    for (int s = 0; s < 600; s++) begin
      r = $urandom_range(0, 39);
      if (r == 0) begin
        if (comp) comp = 1'b0;
        else begin
          cnt = 5'($urandom_range(1, 31));
          r64 = {$urandom(), $urandom()};
          ord = r64[43:0];
          comp = 1'b1;
        end
        cyc($urandom_range(1, 4));
      end else if (r == 1) begin
        rst_n = 1'b0; cyc(1); rst_n = 1'b1; cyc(1);
      end else begin
        hold = $urandom_range(1, 14);
        if (r < 5) btn = 5'($urandom());
        else if (r < 10) btn = '0;
        else btn = 5'(1 << $urandom_range(0, 4));
        cyc(hold);
      end
    end
    btn = '0;
    cyc(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
